// File: rtl/jt12_sh_slot.sv
// ---------------------------------------------------------------------------
// jt12_sh_slot
//
// Slot-indexed circular shift register with a single-entry write port.
// STAGES registers of WIDTH bits form a pipeline. A slot counter (cnt) walks
// 0..STAGES-1 in step with the pipeline. The value leaving the last stage
// (drop) is always the content of slot cnt. It can be recirculated into
// stage 0, or replaced by din. A pending write replaces the entry value when
// its slot comes round.
//
// Parameters
//   WIDTH  : data bits per slot
//   STAGES : number of slots / pipeline depth (2..64)
//   RSTVAL : value loaded into every stage on reset
//   TAP    : index of the intermediate tap stage (0..STAGES-1)
//
// Ports
//   rst      in   asynchronous active-high reset
//   clk      in   clock, rising edge
//   clk_en   in   advance enable for pipeline and slot counter
//   recirc   in   1: feed drop back into stage 0, 0: feed din
//   din      in   shift-in data used when recirc=0
//   wr_req   in   slot-write request (sampled only when not busy)
//   wr_slot  in   target slot of the write request
//   wr_data  in   data for the write request
//   wr_busy  out  an accepted write is pending
//   wr_ack   out  one-cycle pulse after the pending write was committed
//   wr_err   out  one-cycle pulse after a request with an out-of-range slot
//   drop     out  content of stage STAGES-1 (value of slot cnt)
//   tap      out  content of stage TAP
//   cnt      out  current slot counter
//   sync     out  high while cnt==0
// ---------------------------------------------------------------------------
module jt12_sh_slot #(
    parameter int              WIDTH  = 5,
    parameter int              STAGES = 24,
    parameter logic [WIDTH-1:0] RSTVAL = '0,
    parameter int              TAP    = 12
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             clk_en,
    input  logic             recirc,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_req,
    input  logic [5:0]       wr_slot,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_busy,
    output logic             wr_ack,
    output logic             wr_err,
    output logic [WIDTH-1:0] drop,
    output logic [WIDTH-1:0] tap,
    output logic [5:0]       cnt,
    output logic             sync
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [5:0]                     r_cnt;
    logic [5:0]                     r_slot;
    logic [WIDTH-1:0]               r_data;
    logic                           r_ack;
    logic                           r_err;

    logic                           w_accept;
    logic                           w_commit;
    logic                           w_err_next;
    logic                           w_slot_ok;
    logic [WIDTH-1:0]               w_entry;
    logic [STAGES-1:0][WIDTH-1:0]   w_chain;

    // wr_slot is 6 bits but STAGES may be 64, so compare at 7 bits.
    assign w_slot_ok = ({1'b0, wr_slot} < 7'(STAGES));

    // -----------------------------------------------------------------------
    // Write FSM, next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wr_req) begin
                    if (w_slot_ok) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_PEND;
                    end else begin
                        w_err_next   = 1'b1;
                    end
                end
            end
            ST_PEND: begin
                // New requests are ignored here; only the slot match matters.
                if (clk_en && (r_cnt == r_slot)) begin
                    w_commit     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Write FSM, state and latched request
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_slot  <= 6'd0;
            r_data  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_commit;
            r_err   <= w_err_next;
            if (w_accept) begin
                r_slot <= wr_slot;
                r_data <= wr_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Slot counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 6'd0;
        end else if (clk_en) begin
            if (r_cnt == 6'(STAGES - 1)) begin
                r_cnt <= 6'd0;
            end else begin
                r_cnt <= r_cnt + 6'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Entry value: pending write beats recirculation beats din.
    // w_commit already implies a slot match on an enabled cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        w_entry = din;
        if (w_commit) begin
            w_entry = r_data;
        end else if (recirc) begin
            w_entry = w_chain[STAGES-1];
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline stages
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
            logic [WIDTH-1:0] r_q;
            logic [WIDTH-1:0] w_d;

            if (gi == 0) begin : gen_head
                assign w_d = w_entry;
            end else begin : gen_body
                assign w_d = w_chain[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= RSTVAL;
                end else if (clk_en) begin
                    r_q <= w_d;
                end
            end

            assign w_chain[gi] = r_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign drop    = w_chain[STAGES-1];
    assign tap     = w_chain[TAP];
    assign cnt     = r_cnt;
    assign sync    = (r_cnt == 6'd0);
    assign wr_busy = (r_state == ST_PEND);
    assign wr_ack  = r_ack;
    assign wr_err  = r_err;

endmodule

// File: doc/jt12_sh_slot.md
JT12_SH_SLOT -- requirements
Module: jt12_sh_slot

Interface
REQ-001 Parameter WIDTH, default 5: data bits per slot.
REQ-002 Parameter STAGES, default 24: number of slots (pipeline depth); legal range 2..64.
REQ-003 Parameter RSTVAL, default 0: WIDTH-bit value loaded into every stage at reset.
REQ-004 Parameter TAP, default 12: index of the intermediate tap stage; legal range 0..STAGES-1.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port clk, input, 1: single clock; all state SHALL update on its rising edge only.
REQ-007 Port clk_en, input, 1: advance enable for the pipeline and the slot counter.
REQ-008 Port recirc, input, 1: 1 = the drop output is fed back to stage 0; 0 = din is fed to stage 0.
REQ-009 Port din, input, WIDTH: shift-in data, used when recirc=0.
REQ-010 Port wr_req, input, 1: slot-write request, sampled only while wr_busy=0.
REQ-011 Port wr_slot, input, 6: target slot of the write request.
REQ-012 Port wr_data, input, WIDTH: data for the write request.
REQ-013 Port wr_busy, output, 1: an accepted write is pending.
REQ-014 Port wr_ack, output, 1: one-cycle pulse when the pending write has been committed.
REQ-015 Port wr_err, output, 1: one-cycle pulse when a request is rejected.
REQ-016 Port drop, output, WIDTH: content of the last stage (STAGES-1); this is the value of slot cnt.
REQ-017 Port tap, output, WIDTH: content of stage TAP.
REQ-018 Port cnt, output, 6: current slot counter.
REQ-019 Port sync, output, 1: combinational, high when cnt==0.

Function
REQ-020 The pipeline SHALL be STAGES registers of WIDTH bits; on clk_en=1, stage k SHALL take stage k-1 and stage 0 SHALL take the entry value E.
REQ-021 Entry value E SHALL be selected by priority: (1) pending wr_data, if wr_busy=1 and the latched slot equals cnt; (2) drop, if recirc=1; (3) din otherwise.
REQ-022 cnt SHALL increment on each clk_en=1 cycle and wrap from STAGES-1 to 0.
REQ-023 With clk_en=0, pipeline, cnt and pending write SHALL hold; wr_ack SHALL NOT pulse.
REQ-024 With recirc=1 and no writes, drop SHALL repeat with period STAGES clk_en cycles.
REQ-025 Write FSM states: IDLE, PEND.
REQ-026 IDLE, wr_req=1, wr_slot<STAGES: latch wr_slot and wr_data, go to PEND; wr_busy=1 from the next cycle.
REQ-027 IDLE, wr_req=1, wr_slot>=STAGES: stay in IDLE; wr_err=1 for one cycle on the next cycle; nothing latched.
REQ-028 PEND: on the first clk_en=1 cycle with cnt==latched slot, commit the write per REQ-021, return to IDLE; wr_ack=1 and wr_busy=0 on the next cycle.
REQ-029 wr_req while in PEND SHALL be ignored; no error and no overwrite of the latched data.
REQ-030 A write accepted while cnt already equals wr_slot SHALL commit at the next matching slot, at most STAGES clk_en cycles later.
REQ-031 A committed slot value SHALL appear on tap TAP+1 clk_en cycles after commit and on drop STAGES clk_en cycles after commit.
REQ-032 A committed value SHALL recirculate only if recirc=1 when it reaches drop.
REQ-033 A write to slot s SHALL commit regardless of recirc (priority 1 in REQ-021).

Reset
REQ-034 rst=1 SHALL immediately, without a clock edge, force every stage to RSTVAL, cnt=0, the FSM to IDLE, and wr_busy=0, wr_ack=0, wr_err=0; sync is therefore 1.
REQ-035 Reset asserted during PEND SHALL discard the pending write with no ack.
REQ-036 The first clk_en after reset release SHALL shift E into stage 0 with cnt going 0->1.

Verification
REQ-037 Reset with WIDTH=5, STAGES=24, RSTVAL=5'h1F -> drop=tap=5'h1F, cnt=0, sync=1, wr_busy=0.
REQ-038 recirc=0, din=cnt value for 24 clk_en, then recirc=1 -> drop sequence 0,1,...,23 repeats indefinitely.
REQ-039 recirc=1, write slot 7 data 5'h0A while cnt=3 -> commit at cnt=7; wr_ack 1 cycle later; drop=5'h0A whenever cnt=7 afterwards.
REQ-040 wr_slot=30 -> single wr_err pulse, wr_busy stays 0, pipeline unchanged; a second wr_req during PEND -> ignored.
REQ-041 clk_en toggling 1/0 with a write pending for slot 0 -> cnt and data hold on clk_en=0 cycles; commit only on a clk_en cycle with cnt=0.
REQ-042 rst pulse mid-PEND between clock edges -> outputs reset asynchronously, no wr_ack, slot unwritten.
